// File: rtl/song_sequencer_if.sv
// Note-load handshake between the song sequencer (master) and the note player (slave).
interface song_sequencer_if;
  logic [5:0] note_to_load;
  logic [5:0] duration_to_load;
  logic       load_new_note;
  logic       done_with_note;

  modport master (
    output note_to_load, duration_to_load, load_new_note,
    input  done_with_note
  );
  modport slave (
    input  note_to_load, duration_to_load, load_new_note,
    output done_with_note
  );
endinterface

// File: rtl/song_sequencer.sv
// Walks a song ROM and hands one note at a time to the note player, waiting for the
// player's done level before fetching the next entry.
module song_sequencer #(
  parameter  int SONG_BITS = 2,
  parameter  int NOTE_BITS = 5,
  localparam int ADDR_W    = SONG_BITS + NOTE_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 play,
  input  logic [SONG_BITS-1:0] song_sel,
  input  logic                 restart,
  output logic [ADDR_W-1:0]    rom_addr,
  input  logic [11:0]          rom_data,
  song_sequencer_if.master     player,
  output logic                 song_done,
  output logic                 busy
);

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, LOAD, ARM, WAIT, DONE} state_t;

  state_t               state;
  logic [SONG_BITS-1:0] song_reg;
  logic [NOTE_BITS-1:0] note_idx;
  logic [5:0]           note_q;
  logic [5:0]           dur_q;
  logic                 load_q;

  logic [5:0] rom_note;
  logic [5:0] rom_dur;
  assign rom_note = rom_data[11:6];
  assign rom_dur  = rom_data[5:0];

  assign rom_addr                = {song_reg, note_idx};
  assign player.note_to_load     = note_q;
  assign player.duration_to_load = dur_q;
  // A paused LOAD keeps load_q set; the strobe goes out on the cycle play returns.
  assign player.load_new_note    = load_q & play;
  assign busy                    = (state != IDLE) && (state != DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      song_reg  <= '0;
      note_idx  <= '0;
      note_q    <= '0;
      dur_q     <= '0;
      load_q    <= 1'b0;
      song_done <= 1'b0;
    end else if (restart) begin
      state     <= IDLE;
      note_idx  <= '0;
      load_q    <= 1'b0;
      song_done <= 1'b0;
    end else if (play) begin
      load_q <= 1'b0;
      case (state)
        IDLE: begin
          song_reg <= song_sel;
          note_idx <= '0;
          state    <= FETCH;
        end
        FETCH: state <= DECODE;
        DECODE: begin
          if (rom_dur == 6'd0) begin
            state     <= DONE;
            song_done <= 1'b1;
          end else begin
            note_q <= rom_note;
            dur_q  <= rom_dur;
            load_q <= 1'b1;
            state  <= LOAD;
          end
        end
        LOAD: state <= ARM;
        // The player's done is stale until it has reloaded its duration.
        ARM:  state <= WAIT;
        WAIT: begin
          if (player.done_with_note) begin
            if (&note_idx) begin
              state     <= DONE;
              song_done <= 1'b1;
            end else begin
              note_idx <= note_idx + 1'b1;
              state    <= FETCH;
            end
          end
        end
        DONE:    state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
